mem_request_unit: RTL and testbench

- Initiator-side controller for the single-port synchronous data memory (ports data/addr/we/clk/q).
- Accepts load/store requests from the processor datapath over a valid/ready handshake and issues word accesses to memory, one per clock.
- Supports single accesses and fixed-length bursts: burst reads stream data back; burst writes fill consecutive words with one value.
- Sits between the processor's load/store stage and the memory instance, and is the only driver of memory data, addr and we.

---
 rtl/mem_request_unit_if.sv | 63 ++++++
 rtl/mem_request_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_request_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_request_unit_if.sv
// rtl/mem_request_unit_if.sv - request, response and memory-side signal bundle for mem_request_unit
//
// Purpose: carries every non-clock/reset signal of mem_request_unit.
//   master modport : requester plus memory side (drives requests and mem_q,
//                    observes ready/response/busy and memory controls)
//   slave modport  : the mem_request_unit itself
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_len : request handshake
//   rsp_valid/rsp_data                                    : read return pulses
//   busy                                                  : request in progress
//   mem_addr/mem_data/mem_we                              : to memory (registered)
//   mem_q                                                 : from memory
interface mem_request_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [LEN_W-1:0]  req_len;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_len,
        output mem_q,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  busy,
        input  mem_addr,
        input  mem_data,
        input  mem_we
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_len,
        input  mem_q,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output busy,
        output mem_addr,
        output mem_data,
        output mem_we
    );
endinterface

// File: rtl/mem_request_unit.sv
// rtl/mem_request_unit.sv - load/store request controller for a single-port synchronous memory
//
// Purpose: accepts one request at a time over a valid/ready handshake and
// issues one word access per clock to the memory. A request covers
// req_len+1 consecutive words (address wraps modulo 2^ADDR_W). Writes fill
// every word with req_wdata; reads return each word as a one-cycle
// rsp_valid pulse, in address order, with no backpressure.
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : mem_request_unit_if.slave (request, response and memory signals)
module mem_request_unit #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 4,
    parameter int READ_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    mem_request_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Memory-side registers; these feed the memory ports directly.
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              mem_we_q;

    // Response registers.
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    // issuing_q is set while mem_addr_q holds an access still to be
    // performed; rem_issue_q counts the accesses after the current one.
    logic              issuing_q;
    logic [LEN_W-1:0]  rem_issue_q;

    // Read returns still expected after the one currently being captured.
    logic [LEN_W-1:0]  rem_ret_q;

    // One bit per cycle of memory latency: bit j set means the read issued
    // j+1 cycles ago delivers its word on mem_q at the end of this cycle
    // when j reaches READ_LAT-1.
    logic [READ_LAT-1:0] vld_sr_q;

    logic accept;
    logic issue_rd;
    logic last_issue;
    logic capture;
    logic last_ret;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        issue_rd   = 1'b0;
        last_issue = issuing_q && (rem_issue_q == '0);
        capture    = vld_sr_q[READ_LAT-1];
        // The final return retires the request on the same edge that
        // raises its rsp_valid, so a new request can overlap that pulse.
        last_ret   = capture && (rem_ret_q == '0);

        case (state_q)
            IDLE: begin
                if (bus.req_valid && !reset) begin
                    accept  = 1'b1;
                    state_d = bus.req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                if (last_issue) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                issue_rd = issuing_q;
                if (last_ret) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address/data generation, read tracking, response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            issuing_q   <= 1'b0;
            rem_issue_q <= '0;
            rem_ret_q   <= '0;
            vld_sr_q    <= '0;
        end else begin
            // Track which cycles carry a live read on mem_q.
            vld_sr_q[0] <= issue_rd;
            for (int j = 1; j < READ_LAT; j++) begin
                vld_sr_q[j] <= vld_sr_q[j-1];
            end

            rsp_valid_q <= 1'b0;
            if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= bus.mem_q;
                rem_ret_q   <= rem_ret_q - LEN_W'(1);
            end

            if (accept) begin
                // First access goes out in the cycle after the handshake.
                mem_addr_q  <= bus.req_addr;
                mem_we_q    <= bus.req_we;
                issuing_q   <= 1'b1;
                rem_issue_q <= bus.req_len;
                rem_ret_q   <= bus.req_len;
                // Reads leave mem_data untouched; only a fill loads it.
                if (bus.req_we) begin
                    mem_data_q <= bus.req_wdata;
                end
            end else if (issuing_q) begin
                if (last_issue) begin
                    issuing_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end else begin
                    mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                    rem_issue_q <= rem_issue_q - LEN_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// tb/tb_mem_request_unit.sv - table-driven self-checking bench for mem_request_unit
module tb_mem_request_unit;

    logic clk;
    logic reset;

    mem_request_unit_if #(.ADDR_W(16), .DATA_W(16), .LEN_W(4)) bus ();

    mem_request_unit #(
        .ADDR_W(16),
        .DATA_W(16),
        .LEN_W(4),
        .READ_LAT(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one-cycle registered read, write on we. Unwritten words
    // read back as 0xA5A5 ^ addr.
    logic [15:0] mem [0:65535];
    bit          wr  [0:65535];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_data;
            wr[bus.mem_addr]  <= 1'b1;
        end
        bus.mem_q <= wr[bus.mem_addr] ? mem[bus.mem_addr] : (16'hA5A5 ^ bus.mem_addr);
    end

    typedef struct {
        logic        rst;
        logic        v;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [3:0]  len;
        logic        e_ready;
        logic        e_busy;
        logic        e_we;
        logic [15:0] e_addr;
        logic [15:0] e_data;
        logic        e_rv;
        logic [15:0] e_rd;
    } vec_t;

    localparam int NV = 37;
    vec_t vecs [NV];

    int total;
    int passed;

    function automatic vec_t mk(logic rst, logic v, logic we, logic [15:0] a, logic [15:0] d,
                                logic [3:0] l, logic er, logic eb, logic ew, logic [15:0] ea,
                                logic [15:0] ed, logic erv, logic [15:0] erd);
        vec_t r;
        r.rst = rst; r.v = v; r.we = we; r.addr = a; r.wdata = d; r.len = l;
        r.e_ready = er; r.e_busy = eb; r.e_we = ew; r.e_addr = ea; r.e_data = ed;
        r.e_rv = erv; r.e_rd = erd;
        return r;
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end else begin
            passed++;
        end
    endtask

    initial begin
        int pulses;
        total  = 0;
        passed = 0;

        //           rst v  we addr      wdata     len    rdy bsy we addr      data      rv rd
        vecs[0]  = mk(1, 1, 1, 16'h0005, 16'h5555, 4'h0,  0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        vecs[1]  = mk(1, 1, 1, 16'h0005, 16'h5555, 4'h0,  0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        vecs[2]  = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        vecs[3]  = mk(0, 1, 1, 16'h0003, 16'h1111, 4'h0,  1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        vecs[4]  = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 1, 16'h0003, 16'h1111, 0, 16'h0000);
        vecs[5]  = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  1, 0, 0, 16'h0003, 16'h1111, 0, 16'h0000);
        vecs[6]  = mk(0, 1, 0, 16'h0003, 16'hDEAD, 4'h0,  1, 0, 0, 16'h0003, 16'h1111, 0, 16'h0000);
        vecs[7]  = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 0, 16'h0003, 16'h1111, 0, 16'h0000);
        vecs[8]  = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 0, 16'h0003, 16'h1111, 0, 16'h0000);
        vecs[9]  = mk(0, 1, 1, 16'h0008, 16'hABCD, 4'h3,  1, 0, 0, 16'h0003, 16'h1111, 1, 16'h1111);
        vecs[10] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 1, 16'h0008, 16'hABCD, 0, 16'h1111);
        vecs[11] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 1, 16'h0009, 16'hABCD, 0, 16'h1111);
        vecs[12] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 1, 16'h000A, 16'hABCD, 0, 16'h1111);
        vecs[13] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 1, 16'h000B, 16'hABCD, 0, 16'h1111);
        vecs[14] = mk(0, 1, 0, 16'h0008, 16'h0000, 4'h3,  1, 0, 0, 16'h000B, 16'hABCD, 0, 16'h1111);
        vecs[15] = mk(0, 1, 0, 16'hFFFF, 16'h0000, 4'h2,  0, 1, 0, 16'h0008, 16'hABCD, 0, 16'h1111);
        vecs[16] = mk(0, 1, 0, 16'hFFFF, 16'h0000, 4'h2,  0, 1, 0, 16'h0009, 16'hABCD, 0, 16'h1111);
        vecs[17] = mk(0, 1, 0, 16'hFFFF, 16'h0000, 4'h2,  0, 1, 0, 16'h000A, 16'hABCD, 1, 16'hABCD);
        vecs[18] = mk(0, 1, 0, 16'hFFFF, 16'h0000, 4'h2,  0, 1, 0, 16'h000B, 16'hABCD, 1, 16'hABCD);
        vecs[19] = mk(0, 1, 0, 16'hFFFF, 16'h0000, 4'h2,  0, 1, 0, 16'h000B, 16'hABCD, 1, 16'hABCD);
        vecs[20] = mk(0, 1, 0, 16'hFFFF, 16'h0000, 4'h2,  1, 0, 0, 16'h000B, 16'hABCD, 1, 16'hABCD);
        vecs[21] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 0, 16'hFFFF, 16'hABCD, 0, 16'hABCD);
        vecs[22] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 0, 16'h0000, 16'hABCD, 0, 16'hABCD);
        vecs[23] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 0, 16'h0001, 16'hABCD, 1, 16'h5A5A);
        vecs[24] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 0, 16'h0001, 16'hABCD, 1, 16'hA5A5);
        vecs[25] = mk(0, 1, 0, 16'h0000, 16'h0000, 4'h7,  1, 0, 0, 16'h0001, 16'hABCD, 1, 16'hA5A4);
        vecs[26] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 0, 16'h0000, 16'hABCD, 0, 16'hA5A4);
        vecs[27] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 0, 16'h0001, 16'hABCD, 0, 16'hA5A4);
        vecs[28] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 0, 16'h0002, 16'hABCD, 1, 16'hA5A5);
        vecs[29] = mk(1, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 0, 16'h0003, 16'hABCD, 1, 16'hA5A4);
        vecs[30] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        vecs[31] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        vecs[32] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        vecs[33] = mk(0, 1, 1, 16'hFFFF, 16'h7777, 4'h1,  1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        vecs[34] = mk(0, 0, 1, 16'hFFFF, 16'h7777, 4'hF,  0, 1, 1, 16'hFFFF, 16'h7777, 0, 16'h0000);
        vecs[35] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  0, 1, 1, 16'h0000, 16'h7777, 0, 16'h0000);
        vecs[36] = mk(0, 0, 0, 16'h0000, 16'h0000, 4'h0,  1, 0, 0, 16'h0000, 16'h7777, 0, 16'h0000);

        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0005;
        bus.req_wdata = 16'h5555;
        bus.req_len   = 4'h0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            reset         = vecs[i].rst;
            bus.req_valid = vecs[i].v;
            bus.req_we    = vecs[i].we;
            bus.req_addr  = vecs[i].addr;
            bus.req_wdata = vecs[i].wdata;
            bus.req_len   = vecs[i].len;
            @(negedge clk);
            chk("req_ready", i, 16'(bus.req_ready), 16'(vecs[i].e_ready));
            chk("busy",      i, 16'(bus.busy),      16'(vecs[i].e_busy));
            chk("mem_we",    i, 16'(bus.mem_we),    16'(vecs[i].e_we));
            chk("mem_addr",  i, bus.mem_addr,       vecs[i].e_addr);
            chk("mem_data",  i, bus.mem_data,       vecs[i].e_data);
            chk("rsp_valid", i, 16'(bus.rsp_valid), 16'(vecs[i].e_rv));
            chk("rsp_data",  i, bus.rsp_data,       vecs[i].e_rd);
        end

        // Two-word read of the filled region: first pulse 3 cycles after
        // the handshake, then one more, then nothing.
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h000A;
        bus.req_len   = 4'h1;
        @(negedge clk);
        chk("seq_hs_ready", 100, 16'(bus.req_ready), 16'h0001);
        pulses = 0;
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (pulses == 0) begin
                    chk("seq_latency", 100 + t, 16'(t), 16'd3);
                end
                chk("seq_rsp_data", 100 + t, bus.rsp_data, 16'hABCD);
                pulses++;
            end
        end
        chk("seq_pulse_count", 121, 16'(pulses), 16'd2);
        chk("seq_idle_ready", 121, 16'(bus.req_ready), 16'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
